// File: rtl/stochastic_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : stochastic_pkg
// Purpose : Shared types, widths and result scaling for the stochastic decoder
// Revision: 1.0
// ----------------------------------------------------------------------------
package stochastic_pkg;

  localparam int DEF_MAX_LEN_LOG2 = 16;
  localparam int CNT_W            = DEF_MAX_LEN_LOG2 + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Maps a ones count over a 2^l window onto an out_w-bit fraction of full scale,
  // saturating so that a full window of ones reads as all-ones.
  function automatic logic [31:0] sc_scale(input logic [31:0] count,
                                           input logic [4:0]  l,
                                           input int          out_w);
    logic [63:0] s;
    logic [63:0] full;
    full = (64'd1 << out_w) - 64'd1;
    if (int'(l) <= out_w) s = {32'd0, count} << (out_w - int'(l));
    else                  s = {32'd0, count} >> (int'(l) - out_w);
    if (s > full) s = full;
    return s[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_ones_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : sc_ones_counter
// Purpose : Per-channel count of ones seen on one stochastic bitstream
// Revision: 1.0
// ----------------------------------------------------------------------------
module sc_ones_counter
  import stochastic_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_count <= '0;
    else if (clr)           r_count <= '0;
    else if (en && bit_in)  r_count <= r_count + W'(1);
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/stochastic_decoder_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : stochastic_decoder_mc
// Purpose : Multi-channel windowed stochastic-to-binary decoder, valid/ready out
// Revision: 1.0
// ----------------------------------------------------------------------------
module stochastic_decoder_mc
  import stochastic_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int MAX_LEN_LOG2 = 16,
  parameter int OUT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       bits_in,
  input  logic                      bits_valid,
  input  logic                      start,
  input  logic [4:0]                len_log2,
  input  logic                      mode,
  input  logic                      abort,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_value,
  output logic                      overrun
);

  localparam int         c_cnt_w   = MAX_LEN_LOG2 + 1;
  localparam logic [4:0] c_max_len = 5'(MAX_LEN_LOG2);

  state_t                      r_state;
  logic                        r_mode;
  logic [4:0]                  r_len;
  logic [c_cnt_w-1:0]          r_sample_cnt;
  logic                        r_busy;
  logic                        r_out_valid;
  logic [CHANNELS*OUT_W-1:0]   r_out_value;
  logic                        r_overrun;

  logic                        w_take;
  logic                        w_done;
  logic                        w_start_ok;
  logic                        w_clr;
  logic                        w_room;
  logic [c_cnt_w-1:0]          w_target;
  logic [c_cnt_w-1:0]          w_count [CHANNELS];
  logic [c_cnt_w-1:0]          w_final [CHANNELS];
  logic [CHANNELS*OUT_W-1:0]   w_next_value;

  assign w_take     = (r_state == ST_ACCUM) && !abort && bits_valid;
  assign w_target   = c_cnt_w'(1) << r_len;
  assign w_done     = w_take && ((r_sample_cnt + c_cnt_w'(1)) == w_target);
  assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
  assign w_clr      = w_start_ok || abort || w_done;
  assign w_room     = !r_out_valid || out_ready;

  // The final sample of a window is folded in combinationally so the result
  // lands on the same edge that takes that sample.
  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      sc_ones_counter #(
        .W(c_cnt_w)
      ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .en     (w_take),
        .bit_in (bits_in[i]),
        .count  (w_count[i])
      );
      assign w_final[i] = w_count[i] + c_cnt_w'(bits_in[i]);
      assign w_next_value[i*OUT_W +: OUT_W] =
        OUT_W'(sc_scale(32'(w_final[i]), r_len, OUT_W));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_cnt <= '0;
    end else if (w_clr) begin
      r_sample_cnt <= '0;
    end else if (w_take) begin
      r_sample_cnt <= r_sample_cnt + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= 1'b0;
      r_len       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_value <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state   <= ST_ACCUM;
              r_busy    <= 1'b1;
              r_mode    <= mode;
              r_len     <= (len_log2 > c_max_len) ? c_max_len : len_log2;
              r_overrun <= 1'b0;
            end
          end
          ST_ACCUM: begin
            if (w_done && !r_mode) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end

      // A full, unconsumed result register keeps the older result.
      if (w_done) begin
        if (w_room) begin
          r_out_value <= w_next_value;
          r_out_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_value = r_out_value;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_stochastic_decoder_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_stochastic_decoder_mc
// Purpose : Directed + randomized bench for stochastic_decoder_mc (two widths)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_stochastic_decoder_mc;

  localparam int CH  = 4;
  localparam int OW0 = 16;
  localparam int ML0 = 16;
  localparam int OW1 = 8;
  localparam int ML1 = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [CH-1:0]  bits_in;
  logic           bits_valid;
  logic           start;
  logic [4:0]     len_log2;
  logic           mode;
  logic           abort;
  logic           out_ready;

  logic              busy0, out_valid0, overrun0;
  logic [CH*OW0-1:0] out_value0;
  logic              busy1, out_valid1, overrun1;
  logic [CH*OW1-1:0] out_value1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stochastic_decoder_mc #(.CHANNELS(CH), .MAX_LEN_LOG2(ML0), .OUT_W(OW0)) dut0 (
    .clk(clk), .rst(rst), .bits_in(bits_in), .bits_valid(bits_valid),
    .start(start), .len_log2(len_log2), .mode(mode), .abort(abort),
    .busy(busy0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_value(out_value0), .overrun(overrun0));

  stochastic_decoder_mc #(.CHANNELS(CH), .MAX_LEN_LOG2(ML1), .OUT_W(OW1)) dut1 (
    .clk(clk), .rst(rst), .bits_in(bits_in), .bits_valid(bits_valid),
    .start(start), .len_log2(len_log2), .mode(mode), .abort(abort),
    .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_value(out_value1), .overrun(overrun1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: fraction c / 2^l of full scale, i.e. c * 2^ow / 2^l, saturated.
  function automatic longint ref_scale(input longint c, input int l, input int ow);
    longint s;
    longint full;
    s    = (c * (longint'(1) << ow)) / (longint'(1) << l);
    full = (longint'(1) << ow) - 1;
    return (s > full) ? full : s;
  endfunction

  function automatic logic [63:0] ref_pack(input longint cnt[CH], input int l, input int ow);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) v = v | (64'(ref_scale(cnt[i], l, ow)) << (i * ow));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win(input int l, input logic m);
    start = 1'b1; len_log2 = 5'(l); mode = m; bits_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain out_valid", out_valid0, 1'b0);
  endtask

  // gate: 0 every cycle valid, 1 every other cycle, 2 random.
  // kind: 0 random densities, 1 densities 1/0.5/0/0.25, 2 all ones.
  task automatic run_oneshot(input int l, input int gate, input int kind, input string tag);
    longint c[CH];
    int     dens[CH];
    int     nv;
    int     cyc;
    int     target;
    logic   v;
    logic [CH-1:0] b;
    nv = 0; cyc = 0; target = 1 << l;
    for (int i = 0; i < CH; i++) begin c[i] = 0; dens[i] = $urandom_range(0, 4); end
    drain();
    start_win(l, 1'b0);
    check({tag, " busy after start"}, busy0, 1'b1);
    while (nv < target && cyc < 4 * target + 8) begin
      if (gate == 0)      v = 1'b1;
      else if (gate == 1) v = cyc[0];
      else                v = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < CH; i++) begin
        if (kind == 2)      b[i] = 1'b1;
        else if (kind == 1) b[i] = (i == 0) ? 1'b1 : (i == 1) ? (nv % 2 == 0) :
                                   (i == 2) ? 1'b0 : (nv % 4 == 0);
        else                b[i] = ($urandom_range(0, 3) < dens[i]);
      end
      bits_in = b; bits_valid = v;
      tick();
      cyc++;
      if (v) begin
        nv++;
        for (int i = 0; i < CH; i++) c[i] += longint'(b[i]);
      end
      if (nv < target) check({tag, " busy mid"}, busy0, 1'b1);
    end
    bits_valid = 1'b0;
    if (gate == 0) check({tag, " cycles"}, 64'(cyc), 64'(target));
    if (gate == 1) check({tag, " cycles"}, 64'(cyc), 64'(2 * target));
    check({tag, " busy end"},  busy0, 1'b0);
    check({tag, " valid"},     out_valid0, 1'b1);
    check({tag, " value16"},   out_value0, ref_pack(c, l, OW0));
    check({tag, " busy1 end"}, busy1, 1'b0);
    check({tag, " value8"},    64'(out_value1), ref_pack(c, l, OW1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint c0[CH];
    longint c1[CH];
    logic [63:0] exp1;
    logic [CH-1:0] b;

    rst = 1'b1; bits_in = '0; bits_valid = 1'b0; start = 1'b0; len_log2 = '0;
    mode = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst busy",      busy0, 1'b0);
    check("rst out_valid", out_valid0, 1'b0);
    check("rst out_value", out_value0, 64'd0);
    check("rst overrun",   overrun0, 1'b0);
    check("rst value8",    64'(out_value1), 64'd0);

    run_oneshot(10, 0, 1, "const");
    check("const literal", out_value0, 64'h4000_0000_8000_FFFF);
    run_oneshot(4, 1, 2, "gate");
    run_oneshot(0, 0, 0, "l0a");
    run_oneshot(0, 2, 0, "l0b");
    run_oneshot(1, 0, 0, "l1");
    run_oneshot(5, 2, 0, "rnd5");
    run_oneshot(7, 2, 0, "rnd7");

    // Continuous L=3, consumer always ready: one result every 8 samples.
    drain();
    out_ready = 1'b1;
    start_win(3, 1'b1);
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < CH; i++) c0[i] = 0;
      for (int k = 0; k < 8; k++) begin
        b = (w == 0) ? '1 : (w == 1) ? '0 : CH'($urandom);
        bits_in = b; bits_valid = 1'b1;
        tick();
        for (int i = 0; i < CH; i++) c0[i] += longint'(b[i]);
        if (k < 7) check("cont gap", out_valid0, 1'b0);
        else begin
          check("cont valid",   out_valid0, 1'b1);
          check("cont value16", out_value0, ref_pack(c0, 3, OW0));
          check("cont value8",  64'(out_value1), ref_pack(c0, 3, OW1));
          check("cont busy",    busy0, 1'b1);
        end
      end
    end
    bits_valid = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    check("cont abort busy", busy0, 1'b0);

    // Back-pressure, continuous L=2, consumer stalled for 10 cycles.
    drain();
    start_win(2, 1'b1);
    for (int i = 0; i < CH; i++) c0[i] = 0;
    exp1 = '0;
    for (int k = 0; k < 10; k++) begin
      b = CH'($urandom);
      bits_in = b; bits_valid = 1'b1;
      tick();
      if (k < 4) for (int i = 0; i < CH; i++) c0[i] += longint'(b[i]);
      if (k == 3) exp1 = ref_pack(c0, 2, OW0);
      if (k >= 3) begin
        check("bp valid", out_valid0, 1'b1);
        check("bp hold",  out_value0, exp1);
      end
      check("bp overrun", overrun0, (k >= 7) ? 1'b1 : 1'b0);
    end
    check("bp overrun8", overrun1, 1'b1);
    bits_valid = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort busy",    busy0, 1'b0);
    check("abort valid",   out_valid0, 1'b1);
    check("abort value",   out_value0, exp1);
    check("abort overrun", overrun0, 1'b1);
    abort = 1'b1; start = 1'b1; len_log2 = 5'd2; mode = 1'b0;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort+start busy",    busy0, 1'b0);
    check("abort+start overrun", overrun0, 1'b1);
    tick();
    check("abort+start idle", busy0, 1'b0);
    drain();
    start_win(2, 1'b0);
    check("restart overrun clr", overrun0, 1'b0);
    check("restart busy",        busy0, 1'b1);
    abort = 1'b1; tick(); abort = 1'b0;

    // len_log2=31 clamps to each instance's maximum; ch0 gets 300 ones up front.
    drain();
    start_win(31, 1'b0);
    for (int i = 0; i < CH; i++) begin c0[i] = 0; c1[i] = 0; end
    for (int n = 0; n < 65536; n++) begin
      b = CH'($urandom);
      b[0] = (n < 300);
      bits_in = b; bits_valid = 1'b1;
      tick();
      for (int i = 0; i < CH; i++) begin
        c0[i] += longint'(b[i]);
        if (n < 1024) c1[i] += longint'(b[i]);
      end
      if (n == 1023) begin
        check("clamp busy8",   busy1, 1'b0);
        check("clamp value8",  64'(out_value1), ref_pack(c1, ML1, OW1));
        check("clamp ch0 300", 64'(out_value1[7:0]), 64'd75);
        check("clamp busy16 mid", busy0, 1'b1);
      end
      if (n == 65534) check("clamp busy16 pre", busy0, 1'b1);
    end
    bits_valid = 1'b0;
    check("clamp busy16 end", busy0, 1'b0);
    check("clamp value16",    out_value0, ref_pack(c0, ML0, OW0));

    // Asynchronous reset in the middle of a window with a result pending.
    start_win(5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bits_in = CH'($urandom); bits_valid = 1'b1;
      tick();
    end
    check("pre-rst busy",  busy0, 1'b1);
    check("pre-rst valid", out_valid0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async rst busy",  busy0, 1'b0);
    check("async rst valid", out_valid0, 1'b0);
    check("async rst value", out_value0, 64'd0);
    check("async rst ovr",   overrun0, 1'b0);
    check("async rst busy8", busy1, 1'b0);
    bits_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post-rst busy", busy0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stochastic_decoder_mc.md
# stochastic_decoder_mc

Multi-channel stochastic-to-binary decoder: counts ones on CHANNELS parallel bitstreams over a runtime-selectable power-of-two window and emits scaled OUT_W-bit probability estimates through a valid/ready output port. It is the next-generation decoder at the output end of the stochastic compute pipeline. It adds:
- a per-sample input qualifier;
- a continuous back-to-back window mode;
- abort;
- output back-pressure with overrun detection.

## Interface
- CHANNELS, 4: number of independent bitstreams decoded in lockstep.
- MAX_LEN_LOG2, 16: largest window exponent supported; window length = 2^len_log2.
- OUT_W, 16: result width per channel; full scale 2^OUT_W-1 represents 1.0.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bits_in  in  CHANNELS  one stochastic bit per channel; bit i = channel i.
- bits_valid  in  1  bits_in sampled this cycle; cycles with bits_valid=0 are not counted.
- start  in  1  single-cycle pulse; begins a window when in IDLE.
- len_log2  in  5  window exponent, captured on accepted start.
- mode  in  1  0 = one-shot, 1 = continuous; captured on accepted start.
- abort  in  1  terminates accumulation, returns to IDLE.
- busy  out  1  high while in ACCUM.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_value  out  CHANNELS*OUT_W  channel i in bits [i*OUT_W +: OUT_W].
- overrun  out  1  sticky; a completed window was discarded because the result register was full.

## Operation
- FSM states: IDLE and ACCUM.
- IDLE -> ACCUM on start. On that transition:
  - latch mode;
  - latch L = min(len_log2, MAX_LEN_LOG2);
  - clear sample counter and all ones counters;
  - clear overrun.
- start while in ACCUM is ignored.
- ACCUM, per cycle with bits_valid=1: sample counter +1; ones counter of channel i +1 when bits_in[i]=1.
- Counter widths are MAX_LEN_LOG2+1 bits, so a count of 2^MAX_LEN_LOG2 fits.
- Window completes on the cycle the 2^L-th valid sample is taken; that sample is included in the counts.
- On completion:
  - the result is loaded if the result register is empty or being consumed this cycle; otherwise the result is dropped and overrun is set;
  - mode 0: go to IDLE;
  - mode 1: stay in ACCUM with counters restarted so that the next valid sample is sample 0 of the next window, with no samples lost.
- Scaling per channel, with c = ones count and s = c * 2^OUT_W / 2^L:
  - L <= OUT_W: s = c << (OUT_W-L).
  - L > OUT_W: s = c >> (L-OUT_W), truncating.
  - Result = min(s, 2^OUT_W-1), so c = 2^L maps to all-ones.
- abort, any state: go to IDLE, clear counters. A pending result and out_valid are preserved.
- abort together with start: abort wins, start is ignored.
- Output handshake: out_value is stable while out_valid=1 && out_ready=0. out_valid clears the cycle after acceptance unless a new result loads on the same edge.

## Timing
- Reset values: busy=0, out_valid=0, out_value=0, overrun=0, FSM=IDLE, all counters 0.
- Reset mid-window discards all state immediately (asynchronous).
- start accepted at edge N: busy=1 from N+1. The first countable sample is the one presented in cycle N+1.
- Completion at edge M:
  - out_valid=1 and out_value updated after edge M (zero-cycle latency beyond the final sample edge);
  - one-shot: busy=0 after edge M.
- Continuous mode with bits_valid held high and out_ready held high: one result every 2^L cycles, no gaps.
- L=0 (length 1): every valid sample completes a window. Each result is 0 or 2^OUT_W-1.
- Throughput limit: a consumer stalling longer than one window causes overrun. The older result is kept; the newer is dropped.

## Structure
- Shared package stochastic_pkg holds:
  - state enum (IDLE, ACCUM);
  - scaling function sc_scale(count, L) parameterised on OUT_W and MAX_LEN_LOG2;
  - localparam CNT_W = MAX_LEN_LOG2+1.
- Sub-module sc_ones_counter: one per channel, generated CHANNELS times. Ports: clk, rst, clr, en, bit, count.
- The top level owns the FSM, sample counter, result register, handshake and overrun logic.

## Test plan
- Constant pattern: CHANNELS=4, OUT_W=16, L=10, mode 0; channel densities 1.0 / 0.5 (alternating) / 0.0 / 0.25 (every fourth bit) -> out_value = 0xFFFF / 0x8000 / 0x0000 / 0x4000; busy drops after exactly 1024 valid samples.
- bits_valid gating: L=4, bits_valid asserted every other cycle, all bits 1 -> completion after 16 valid samples (32 cycles), value 0xFFFF.
- Continuous mode, L=3, out_ready=1: stream of 8 ones then 8 zeros -> results 0xFFFF then 0x0000 on consecutive windows, spaced exactly 8 cycles apart.
- Back-pressure: continuous L=2, out_ready=0 for 10 cycles -> first result held stable, second dropped, overrun=1. Next start clears overrun.
- L > OUT_W scaling: OUT_W=8, L=10, 300 ones -> 300>>2 = 75. L clamp: len_log2=31 with MAX_LEN_LOG2=16 -> window 65536.
- Abort and reset: abort mid-window with a pending result -> busy=0, out_valid and value unchanged. abort+start together -> stays IDLE. rst mid-window -> all outputs 0 immediately.
